// File: rtl/gaussian_pair_gen.sv
// gaussian_pair_gen: two independent xorshift32 channels. Each channel sums NSUM
// 18-bit uniforms into an approximately normal sample. The result is centred to
// signed Q4.18 and presented as a pair behind a valid/ready output register.
// Optional build macro: GAUSS_ANTITHETIC_EN. When defined, each fresh pair that
// is transferred is followed by its negation (-G1,-G2).
//
// state   | meaning
// S_ACCUM | summing uniforms; RNGs, acc and cnt advance on edges with en=1
// S_HOLD  | final sums parked in acc while the output register still holds an unconsumed pair
module gaussian_pair_gen #(
  parameter int          NSUM      = 12,
  parameter logic [31:0] SEED_ZERO = 32'h2545F491
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic        g_ready,
  output logic        g_valid,
  output logic [22:0] G1,
  output logic [22:0] G2
);

  typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [3:0]  CNT_LAST = 4'(NSUM - 1);
  localparam logic [22:0] HALF     = 23'((NSUM / 2) * 262144);

  function automatic logic [31:0] f_xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [22:0] f_center(input logic [21:0] acc);
    return {1'b0, acc} - HALF;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_rng1, r_rng2;
  logic [21:0] r_acc1, r_acc2;
  logic [3:0]  r_cnt;
  logic        r_g_valid;
  logic [22:0] r_g1, r_g2;

  logic [31:0] w_rng1_nxt, w_rng2_nxt;
  logic [21:0] w_sum1, w_sum2;
  logic        w_xfer, w_anti_load, w_adv, w_load_sum, w_load_acc;

  assign w_rng1_nxt = f_xorshift(r_rng1);
  assign w_rng2_nxt = f_xorshift(r_rng2);
  assign w_sum1     = r_acc1 + {4'b0000, w_rng1_nxt[31:14]};
  assign w_sum2     = r_acc2 + {4'b0000, w_rng2_nxt[31:14]};
  assign w_xfer     = r_g_valid & g_ready;

`ifdef GAUSS_ANTITHETIC_EN
  localparam logic [22:0] NEG_HALF = 23'd0 - HALF;

  // -(-NSUM/2) is clamped so the output range stays [-NSUM/2, NSUM/2)
  function automatic logic [22:0] f_negate(input logic [22:0] g);
    return (g == NEG_HALF) ? (HALF - 23'd1) : (23'd0 - g);
  endfunction

  logic r_shown_anti;

  // a transfer of a fresh pair is always answered by its negation
  assign w_anti_load = w_xfer & ~r_shown_anti;

  // tracks whether the pair currently in the output register is the negated one
  always_ff @(posedge clk) begin
    if (rst)                          r_shown_anti <= 1'b0;
    else if (w_load_sum | w_load_acc) r_shown_anti <= 1'b0;
    else if (w_anti_load)             r_shown_anti <= 1'b1;
    else if (w_xfer)                  r_shown_anti <= 1'b0;
  end
`else
  assign w_anti_load = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACCUM;
    else     r_state <= w_state_nxt;
  end

  // next state and datapath controls; antithetic loads freeze accumulation for that edge
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_load_sum  = 1'b0;
    w_load_acc  = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (en && !w_anti_load) begin
          w_adv = 1'b1;
          if (r_cnt == CNT_LAST) begin
            if (!r_g_valid || g_ready) w_load_sum  = 1'b1;
            else                       w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_xfer && !w_anti_load) begin
          w_load_acc  = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  // RNG state: seeded in reset (zero seed replaced), steps only on accumulate edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rng1 <= (seed1 == 32'd0) ? SEED_ZERO : seed1;
      r_rng2 <= (seed2 == 32'd0) ? SEED_ZERO : seed2;
    end else if (w_adv) begin
      r_rng1 <= w_rng1_nxt;
      r_rng2 <= w_rng2_nxt;
    end
  end

  // running sums and uniform counter; the final sum stays in acc while in S_HOLD
  always_ff @(posedge clk) begin
    if (rst || w_load_sum || w_load_acc) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_cnt  <= '0;
    end else if (w_adv) begin
      r_acc1 <= w_sum1;
      r_acc2 <= w_sum2;
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  // output register: loads a new pair, or drops valid after a transfer with nothing to replace it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g1      <= '0;
      r_g2      <= '0;
      r_g_valid <= 1'b0;
    end else if (w_load_sum) begin
      r_g1      <= f_center(w_sum1);
      r_g2      <= f_center(w_sum2);
      r_g_valid <= 1'b1;
    end else if (w_load_acc) begin
      r_g1      <= f_center(r_acc1);
      r_g2      <= f_center(r_acc2);
      r_g_valid <= 1'b1;
`ifdef GAUSS_ANTITHETIC_EN
    end else if (w_anti_load) begin
      r_g1      <= f_negate(r_g1);
      r_g2      <= f_negate(r_g2);
      r_g_valid <= 1'b1;
`endif
    end else if (w_xfer) begin
      r_g_valid <= 1'b0;
    end
  end

  assign g_valid = r_g_valid;
  assign G1      = r_g1;
  assign G2      = r_g2;

endmodule

// File: tb/tb_gaussian_pair_gen.sv
// Scoreboard bench for gaussian_pair_gen (default build, NSUM=12).
// Stimulus pushes the expected pair sequence for each seed setting; a negedge
// monitor pops and compares on every transfer and checks hold stability.
module tb_gaussian_pair_gen;

  localparam logic [31:0] SEED_ZERO = 32'h2545F491;
  localparam logic [22:0] HALF      = 23'h180000;
  localparam int          NPAIRS    = 120;

  typedef struct {
    logic [22:0] g1;
    logic [22:0] g2;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        g_ready = 1'b0;
  logic [31:0] seed1 = 32'd0;
  logic [31:0] seed2 = 32'd0;
  logic        g_valid;
  logic [22:0] G1, G2;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  pair_t sb_q[$];
  int    xfer_t[$];

  logic        prev_hold = 1'b0;
  logic [22:0] prev_g1 = '0;
  logic [22:0] prev_g2 = '0;

  gaussian_pair_gen dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .seed1   (seed1),
    .seed2   (seed2),
    .g_ready (g_ready),
    .g_valid (g_valid),
    .G1      (G1),
    .G2      (G2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // reference sequence: pair k is built from uniforms 12k..12k+11 of each channel
  task automatic push_pairs(input logic [31:0] s1, input logic [31:0] s2, input int n);
    logic [31:0] x1, x2;
    logic [21:0] a1, a2;
    pair_t       p;
    x1 = (s1 == 32'd0) ? SEED_ZERO : s1;
    x2 = (s2 == 32'd0) ? SEED_ZERO : s2;
    for (int k = 0; k < n; k++) begin
      a1 = '0;
      a2 = '0;
      for (int j = 0; j < 12; j++) begin
        x1 = xs(x1);
        x2 = xs(x2);
        a1 = a1 + {4'b0000, x1[31:14]};
        a2 = a2 + {4'b0000, x2[31:14]};
      end
      p.g1 = {1'b0, a1} - HALF;
      p.g2 = {1'b0, a2} - HALF;
      sb_q.push_back(p);
    end
  endtask

  // monitor: inputs change at posedge+1/+2, so the negedge sees settled values
  always @(negedge clk) begin
    pair_t p;
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && g_valid) begin
        chk("hold_stable_g1", G1, prev_g1);
        chk("hold_stable_g2", G2, prev_g2);
      end
      if (g_valid && g_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          p = sb_q.pop_front();
          chk("pair_g1", G1, p.g1);
          chk("pair_g2", G2, p.g2);
        end
        xfer_t.push_back(cyc);
      end
      prev_hold <= g_valid && !g_ready;
      prev_g1   <= G1;
      prev_g2   <= G2;
    end
  end

  task automatic do_reset(input logic [31:0] s1, input logic [31:0] s2, input logic rdy);
    rst     = 1'b1;
    en      = 1'b0;
    g_ready = 1'b0;
    seed1   = s1;
    seed2   = s2;
    repeat (3) @(posedge clk);
    sb_q.delete();
    xfer_t.delete();
    push_pairs(s1, s2, NPAIRS);
    #1;
    chk("reset_g1", G1, 0);
    chk("reset_g2", G2, 0);
    chk("reset_valid", g_valid, 0);
    #1;
    rst     = 1'b0;
    en      = 1'b1;
    g_ready = rdy;
  endtask

  // counts en-phase edges after reset release until g_valid; en dropped for pause_len edges after edge pause_at
  task automatic wait_valid(output int n, input int pause_at, input int pause_len);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (g_valid) begin
        n = i;
        break;
      end
      #1;
      en = (pause_len > 0 && i >= pause_at && i < pause_at + pause_len) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int n;
    int valid_drops;

    chk("model_xorshift_seed1", xs(32'd1), 32'h00042021);
    chk("model_first_u", xs(32'd1) >> 14, 18'h10);

    // reset values, first-valid latency, steady 12-cycle spacing; seed2=0 exercises SEED_ZERO
    do_reset(32'd1, 32'd0, 1'b1);
    wait_valid(n, 0, 0);
    chk("first_valid_latency", n, 12);
    repeat (50) @(posedge clk);
    chk("p1_xfer_count", xfer_t.size(), 5);
    if (xfer_t.size() >= 3) begin
      chk("p1_spacing_a", xfer_t[1] - xfer_t[0], 12);
      chk("p1_spacing_b", xfer_t[2] - xfer_t[1], 12);
    end

    // backpressure: 30 cycles of g_ready=0 right after the first valid
    do_reset(32'h12345678, 32'hDEADBEEF, 1'b1);
    wait_valid(n, 0, 0);
    chk("bp_first_valid_latency", n, 12);
    g_ready = 1'b0;
    valid_drops = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (!g_valid) valid_drops++;
    end
    chk("bp_valid_held", valid_drops, 0);
    chk("bp_no_xfer_while_stalled", xfer_t.size(), 0);
    #1 g_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (xfer_t.size() >= 4) break;
    end
    chk("bp_xfers_reached", (xfer_t.size() >= 4) ? 1 : 0, 1);
    if (xfer_t.size() >= 4) begin
      chk("bp_back_to_back", xfer_t[1] - xfer_t[0], 1);
      chk("bp_spacing_a", xfer_t[2] - xfer_t[1], 12);
      chk("bp_spacing_b", xfer_t[3] - xfer_t[2], 12);
    end

    // park the block in S_HOLD, then reset over it (reset checks inside do_reset)
    #2 g_ready = 1'b0;
    repeat (30) @(posedge clk);

    // pause: en low for 5 edges once cnt reaches 6
    do_reset(32'hCAFEF00D, 32'h0BADC0DE, 1'b1);
    wait_valid(n, 6, 5);
    chk("pause_valid_latency", n, 17);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (xfer_t.size() >= 3) break;
    end
    chk("pause_xfers_reached", (xfer_t.size() >= 3) ? 1 : 0, 1);

    // random en / g_ready, both seeds zero, 100 pairs against the reference sequence
    do_reset(32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      if (xfer_t.size() >= 100) break;
      #2;
      en      = ($urandom_range(0, 3) != 0);
      g_ready = ($urandom_range(0, 2) != 0);
    end
    chk("random_xfers_reached", (xfer_t.size() >= 100) ? 1 : 0, 1);
    chk("random_sb_remaining", sb_q.size(), NPAIRS - 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
